// File: rtl/addsub_sequencer.sv
// Three-state sequencer around an external 4-bit ripple adder-subtractor:
// latches a request, runs one EXEC cycle, holds the result until consumed.
module addsub_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] op_a,
    input  logic [3:0] op_b,
    input  logic       op_sub,
    input  logic       acc_en,
    input  logic       clr,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    output logic       add_mode,
    output logic       add_cin,
    input  logic [3:0] add_s,
    input  logic       add_cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] res,
    output logic       flag_c,
    output logic       flag_v,
    output logic       flag_z,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] lat_a;
    logic [3:0] lat_b;
    logic       lat_sub;
    logic [3:0] acc;
    logic       accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Adder operands come only from the latched copies so they never follow live inputs.
    assign add_a    = lat_a;
    assign add_b    = lat_b;
    assign add_mode = lat_sub;
    assign add_cin  = lat_sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_a    <= 4'd0;
            lat_b    <= 4'd0;
            lat_sub  <= 1'b0;
            res      <= 4'd0;
            flag_c   <= 1'b0;
            flag_v   <= 1'b0;
            flag_z   <= 1'b0;
            acc      <= 4'd0;
            op_count <= 8'd0;
        end else begin
            if (accept) begin
                lat_a   <= acc_en ? acc : op_a;
                lat_b   <= op_b;
                lat_sub <= op_sub;
            end
            if (state == EXEC) begin
                res    <= add_s;
                flag_c <= add_cout ^ lat_sub;
                flag_v <= (lat_a[3] == (lat_b[3] ^ lat_sub)) && (add_s[3] != lat_a[3]);
                flag_z <= (add_s == 4'd0);
            end
            // A clear overrides the accumulator/counter update of a coinciding capture.
            if (clr) begin
                acc      <= 4'd0;
                op_count <= 8'd0;
            end else if (state == EXEC) begin
                acc      <= add_s;
                op_count <= op_count + 8'd1;
            end
        end
    end

endmodule
